// File: rtl/nexys_starship_pkg.sv
// Shared types and widths for the starship room-repair controller.
// State encoding is one-hot, so the state flags are taken straight from the state flops.
package nexys_starship_pkg;

    localparam int CODE_W    = 4;
    localparam int DONE_W    = 8;
    localparam int WRONG_W   = 3;
    localparam int TIMEOUT_W = 8;

    typedef enum logic [2:0] {
        ST_INIT    = 3'b001,
        ST_WORKING = 3'b010,
        ST_REPAIR  = 3'b100
    } room_state_t;

    localparam logic [DONE_W-1:0] DONE_MAX = '1;

    // Saturating increment for the repair tally.
    function automatic logic [DONE_W-1:0] sat_inc_done(input logic [DONE_W-1:0] v);
        return (v == DONE_MAX) ? v : v + DONE_W'(1);
    endfunction

endpackage

// File: rtl/nexys_starship_tick_timeout.sv
// Repair timeout counter: counts timer ticks while a room is broken.
// Only compiled when NEXYS_STARSHIP_REPAIR_TIMEOUT_EN is defined.
// done is a same-cycle strobe: high on the tick that brings the count to limit,
// so the parent can register game-over on that very edge.
`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
module nexys_starship_tick_timeout
    import nexys_starship_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 clear,
    input  logic                 tick,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 done
);

    logic [TIMEOUT_W-1:0] count;
    logic [TIMEOUT_W:0]   count_plus;

    assign count_plus = {1'b0, count} + (TIMEOUT_W+1)'(1);
    assign done       = tick && (count_plus >= {1'b0, limit});

    // Tick counter, cleared when a new breakage is latched; saturates at all-ones.
    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (tick && (count != '1)) begin
            count <= count_plus[TIMEOUT_W-1:0];
        end
    end

endmodule
`endif

// File: rtl/nexys_starship_room_repair.sv
// Starship room-repair FSM: a room breaks on request, the player must enter the
// latched code before running out of wrong guesses (or, with
// NEXYS_STARSHIP_REPAIR_TIMEOUT_EN defined, before the tick timeout expires).
//
// state      | meaning
// -----------+------------------------------------------------
// ST_INIT    | waiting for the game to enter Play
// ST_WORKING | room operational, breakage requests accepted
// ST_REPAIR  | room broken, repair attempts evaluated
module nexys_starship_room_repair
    import nexys_starship_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 10,
    parameter int MAX_WRONG     = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              play_flag,
    input  logic              gameover_ctrl,
    input  logic              timer_tick,
    input  logic              break_req,
    input  logic              btn_pulse,
    input  logic [CODE_W-1:0] hex_combo,
    input  logic [CODE_W-1:0] random_hex,
    output logic              q_Init,
    output logic              q_Working,
    output logic              q_Repair,
    output logic              room_broken,
    output logic              room_gameover,
    output logic [CODE_W-1:0] repair_code,
    output logic [DONE_W-1:0] repairs_done
);

    room_state_t        state;
    logic [WRONG_W-1:0] wrong_cnt;
    logic [WRONG_W:0]   wrong_plus;
    logic               wrong_hit;
    logic               code_ok;
    logic               timeout_hit;

    // One-hot encoding: each flag is a state flop bit, hence registered.
    assign q_Init      = state[0];
    assign q_Working   = state[1];
    assign q_Repair    = state[2];
    assign room_broken = state[2];

    assign code_ok    = (hex_combo == repair_code);
    assign wrong_plus = {1'b0, wrong_cnt} + (WRONG_W+1)'(1);
    assign wrong_hit  = (wrong_plus >= (WRONG_W+1)'(MAX_WRONG));

`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
    logic timeout_clear;
    logic timeout_tick;

    assign timeout_clear = q_Working && break_req && !gameover_ctrl;
    assign timeout_tick  = q_Repair && timer_tick && !gameover_ctrl;

    nexys_starship_tick_timeout u_timeout (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (timeout_clear),
        .tick  (timeout_tick),
        .limit (TIMEOUT_W'(TIMEOUT_TICKS)),
        .done  (timeout_hit)
    );
`else
    logic unused_timer_tick;
    assign unused_timer_tick = timer_tick;
    assign timeout_hit       = 1'b0;
`endif

    // Room FSM with registered code, wrong-guess count, game-over and repair tally.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= ST_INIT;
            repair_code   <= '0;
            repairs_done  <= '0;
            wrong_cnt     <= '0;
            room_gameover <= 1'b0;
        end else begin
            // Game-over contribution is held until the FSM has settled in INIT.
            if (state == ST_INIT) begin
                room_gameover <= 1'b0;
            end
            if (gameover_ctrl) begin
                state <= ST_INIT;
            end else begin
                case (state)
                    ST_INIT: begin
                        if (play_flag) begin
                            state <= ST_WORKING;
                        end
                    end
                    ST_WORKING: begin
                        // A break wins over a simultaneous button press; presses here are ignored.
                        if (break_req) begin
                            state       <= ST_REPAIR;
                            repair_code <= random_hex;
                            wrong_cnt   <= '0;
                        end
                    end
                    ST_REPAIR: begin
                        // A correct code beats any expiry arriving on the same edge.
                        if (btn_pulse && code_ok) begin
                            state        <= ST_WORKING;
                            repairs_done <= sat_inc_done(repairs_done);
                        end else begin
                            if (btn_pulse) begin
                                if (wrong_cnt != '1) begin
                                    wrong_cnt <= wrong_plus[WRONG_W-1:0];
                                end
                                if (wrong_hit) begin
                                    room_gameover <= 1'b1;
                                end
                            end
                            if (timeout_hit) begin
                                room_gameover <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_INIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nexys_starship_room_repair.sv
// Directed bench for nexys_starship_room_repair (default parameters).
// Timeout scenarios follow NEXYS_STARSHIP_REPAIR_TIMEOUT_EN when the bench is built with it.
module tb_nexys_starship_room_repair;

    localparam int ST_I = 0;
    localparam int ST_W = 1;
    localparam int ST_R = 2;

    typedef struct {
        logic       play;
        logic       go;
        logic       tick;
        logic       brk;
        logic       btn;
        logic [3:0] combo;
        logic [3:0] rhex;
        int         st;
        logic       gover;
        logic [3:0] code;
        logic [7:0] done;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       play_flag, gameover_ctrl, timer_tick, break_req, btn_pulse;
    logic [3:0] hex_combo, random_hex;
    logic       q_Init, q_Working, q_Repair, room_broken, room_gameover;
    logic [3:0] repair_code;
    logic [7:0] repairs_done;

    int n_tests = 0;
    int n_fail  = 0;

    nexys_starship_room_repair dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .play_flag     (play_flag),
        .gameover_ctrl (gameover_ctrl),
        .timer_tick    (timer_tick),
        .break_req     (break_req),
        .btn_pulse     (btn_pulse),
        .hex_combo     (hex_combo),
        .random_hex    (random_hex),
        .q_Init        (q_Init),
        .q_Working     (q_Working),
        .q_Repair      (q_Repair),
        .room_broken   (room_broken),
        .room_gameover (room_gameover),
        .repair_code   (repair_code),
        .repairs_done  (repairs_done)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic play, input logic go, input logic tick,
                                input logic brk, input logic btn, input logic [3:0] combo,
                                input logic [3:0] rhex, input int st, input logic gover,
                                input logic [3:0] code, input logic [7:0] done);
        vec_t v;
        v.play = play; v.go = go; v.tick = tick; v.brk = brk; v.btn = btn;
        v.combo = combo; v.rhex = rhex; v.st = st; v.gover = gover;
        v.code = code; v.done = done;
        return v;
    endfunction

    task automatic check(input string name, input vec_t v);
        logic [3:0]  exp_flags;
        logic [16:0] exp_all, got_all;
        exp_flags = (v.st == ST_I) ? 4'b1000 : (v.st == ST_W) ? 4'b0100 : 4'b0011;
        exp_all = {exp_flags, v.gover, v.code, v.done};
        got_all = {q_Init, q_Working, q_Repair, room_broken, room_gameover, repair_code, repairs_done};
        n_tests++;
        if (got_all !== exp_all) begin
            n_fail++;
            $display("FAIL %s: got init/work/rep/brk=%b gover=%b code=%h done=%0d, expected init/work/rep/brk=%b gover=%b code=%h done=%0d",
                     name, got_all[16:13], got_all[12], got_all[11:8], got_all[7:0],
                     exp_flags, v.gover, v.code, v.done);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        play_flag     = v.play;
        gameover_ctrl = v.go;
        timer_tick    = v.tick;
        break_req     = v.brk;
        btn_pulse     = v.btn;
        hex_combo     = v.combo;
        random_hex    = v.rhex;
        @(posedge Clk);
        #1;
        check(name, v);
    endtask

    vec_t vecs[20];

    initial begin
        // play go tick brk btn combo rhex | st gover code done
        vecs[0]  = mk(1,0,0,0,0,4'h0,4'h0, ST_W,0,4'h0,8'd0); // start play
        vecs[1]  = mk(1,0,0,0,1,4'hA,4'h0, ST_W,0,4'h0,8'd0); // btn ignored in WORKING
        vecs[2]  = mk(1,0,0,1,1,4'h0,4'hA, ST_R,0,4'hA,8'd0); // break wins over btn
        vecs[3]  = mk(1,0,0,1,0,4'h0,4'h5, ST_R,0,4'hA,8'd0); // break ignored, no relatch
        vecs[4]  = mk(1,0,0,0,1,4'hA,4'h0, ST_W,0,4'hA,8'd1); // correct repair
        vecs[5]  = mk(1,0,0,1,0,4'h0,4'h5, ST_R,0,4'h5,8'd1); // break code 5
        vecs[6]  = mk(1,0,0,0,1,4'h3,4'h0, ST_R,0,4'h5,8'd1); // wrong 1
        vecs[7]  = mk(1,0,0,0,1,4'h3,4'h0, ST_R,0,4'h5,8'd1); // wrong 2
        vecs[8]  = mk(1,0,0,0,0,4'h3,4'h0, ST_R,0,4'h5,8'd1); // idle
        vecs[9]  = mk(1,0,0,0,1,4'h3,4'h0, ST_R,1,4'h5,8'd1); // wrong 3 -> gameover
        vecs[10] = mk(1,1,0,0,0,4'h0,4'h0, ST_I,1,4'h5,8'd1); // forced INIT, gover held
        vecs[11] = mk(0,0,0,0,0,4'h0,4'h0, ST_I,0,4'h5,8'd1); // gover clears in INIT
        vecs[12] = mk(1,0,0,0,0,4'h0,4'h0, ST_W,0,4'h5,8'd1);
        vecs[13] = mk(1,0,0,1,0,4'h0,4'hC, ST_R,0,4'hC,8'd1); // new break clears wrong count
        vecs[14] = mk(1,0,0,0,1,4'h3,4'h0, ST_R,0,4'hC,8'd1); // single wrong, no gameover
        vecs[15] = mk(1,0,0,0,1,4'hC,4'h0, ST_W,0,4'hC,8'd2);
        vecs[16] = mk(1,1,0,1,0,4'h0,4'h0, ST_I,0,4'hC,8'd2); // gameover_ctrl beats break
        vecs[17] = mk(1,1,0,0,0,4'h0,4'h0, ST_I,0,4'hC,8'd2); // gameover_ctrl beats play
        vecs[18] = mk(1,0,0,0,0,4'h0,4'h0, ST_W,0,4'hC,8'd2);
        vecs[19] = mk(1,0,1,0,0,4'h0,4'h0, ST_W,0,4'hC,8'd2); // tick in WORKING ignored

        Reset = 1'b1;
        step("reset_a", mk(1,0,1,1,1,4'h0,4'h7, ST_I,0,4'h0,8'd0));
        step("reset_b", mk(0,0,0,0,0,4'h0,4'h0, ST_I,0,4'h0,8'd0));
        Reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

`ifdef NEXYS_STARSHIP_REPAIR_TIMEOUT_EN
        step("to_break", mk(1,0,0,1,0,4'h0,4'h7, ST_R,0,4'h7,8'd2));
        for (int t = 1; t <= 9; t++)
            step($sformatf("to_tick%0d", t), mk(1,0,1,0,0,4'h0,4'h0, ST_R,0,4'h7,8'd2));
        step("to_tick10", mk(1,0,1,0,0,4'h0,4'h0, ST_R,1,4'h7,8'd2));
        step("to_go",     mk(1,1,0,0,0,4'h0,4'h0, ST_I,1,4'h7,8'd2));
        step("to_clear",  mk(0,0,0,0,0,4'h0,4'h0, ST_I,0,4'h7,8'd2));
        step("to_play",   mk(1,0,0,0,0,4'h0,4'h0, ST_W,0,4'h7,8'd2));
        step("to_break2", mk(1,0,0,1,0,4'h0,4'h7, ST_R,0,4'h7,8'd2));
        for (int t = 1; t <= 9; t++)
            step($sformatf("to2_tick%0d", t), mk(1,0,1,0,0,4'h0,4'h0, ST_R,0,4'h7,8'd2));
        step("to_fix_on_tick10", mk(1,0,1,0,1,4'h7,4'h0, ST_W,0,4'h7,8'd3));
`else
        step("nto_break", mk(1,0,0,1,0,4'h0,4'h7, ST_R,0,4'h7,8'd2));
        for (int t = 1; t <= 20; t++)
            step($sformatf("nto_tick%0d", t), mk(1,0,1,0,0,4'h0,4'h0, ST_R,0,4'h7,8'd2));
        step("nto_fix", mk(1,0,0,0,1,4'h7,4'h0, ST_W,0,4'h7,8'd3));
`endif

        // Reset in the middle of a repair with two wrong guesses outstanding.
        step("rst_break",  mk(1,0,0,1,0,4'h0,4'h9, ST_R,0,4'h9,8'd3));
        step("rst_wrong1", mk(1,0,0,0,1,4'h0,4'h0, ST_R,0,4'h9,8'd3));
        step("rst_wrong2", mk(1,0,0,0,1,4'h0,4'h0, ST_R,0,4'h9,8'd3));
        Reset = 1'b1;
        step("rst_mid",    mk(1,0,0,0,0,4'h0,4'h0, ST_I,0,4'h0,8'd0));
        Reset = 1'b0;
        step("rst_play",   mk(1,0,0,0,0,4'h0,4'h0, ST_W,0,4'h0,8'd0));
        step("rst_break2", mk(1,0,0,1,0,4'h0,4'h9, ST_R,0,4'h9,8'd0));
        step("rst_wrong3", mk(1,0,0,0,1,4'h0,4'h0, ST_R,0,4'h9,8'd0));
        step("rst_fix",    mk(1,0,0,0,1,4'h9,4'h0, ST_W,0,4'h9,8'd1));

        // 255 more repairs (256 since reset): tally must stop at 255.
        for (int k = 2; k <= 256; k++) begin
            step("sat_break", mk(1,0,0,1,0,4'h0,4'h6, ST_R,0,4'h6,8'((k - 1 > 255) ? 255 : k - 1)));
            step($sformatf("sat_fix%0d", k), mk(1,0,0,0,1,4'h6,4'h0, ST_W,0,4'h6,8'((k > 255) ? 255 : k)));
        end
        step("sat_hold", mk(1,0,0,0,0,4'h0,4'h0, ST_W,0,4'h6,8'd255));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
